// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sipo_if.sv
// Received-byte holding register handshake plus status flags of the UART receiver.
interface uart_rx_sipo_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      ready;
  logic                      frame_err;
  logic                      overrun;
  logic                      busy;

  modport master (output data, valid, frame_err, overrun, busy, input ready);
  modport slave  (input data, valid, frame_err, overrun, busy, output ready);
endinterface

// File: rtl/uart_rx_sipo_sync2.sv
// Two-flop synchronizer with a configurable reset value (idle level of the line).
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_reg <= {2{RST_VAL}};
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/uart_rx_sipo.sv
// 8N1 UART receiver: mid-bit oversampled deserializer feeding a valid/ready
// holding register, with framing and overrun pulses.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          rxd,
  uart_rx_sipo_if.master rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

  logic                      rxs;
  uart_rx_state_t            state_reg, state_next;
  logic [CW-1:0]             cnt_reg, cnt_next;
  logic [BW-1:0]             bit_idx_reg, bit_idx_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next, shift_in;
  logic [UART_DATA_BITS-1:0] data_reg;
  logic                      valid_reg, frame_err_reg, overrun_reg;
  logic                      stop_sample, load, drop, ferr;

  sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .clr(clr), .d(rxd), .q(rxs));

  // Shift direction picks which neighbour feeds each bit; the end bit takes rxs.
  for (genvar gi = 0; gi < UART_DATA_BITS; gi++) begin : g_shift
    localparam int SRC = MSB_FIRST ? gi - 1 : gi + 1;
    if (SRC < 0 || SRC >= UART_DATA_BITS) begin : g_edge
      assign shift_in[gi] = rxs;
    end else begin : g_mid
      assign shift_in[gi] = shift_reg[SRC];
    end
  end

  assign stop_sample = (state_reg == STOP) && (cnt_reg == CNT_FULL);
  assign load        = stop_sample && rxs && (!valid_reg || rx.ready);
  assign drop        = stop_sample && rxs && valid_reg && !rx.ready;
  assign ferr        = stop_sample && !rxs;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 1'b1;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rxs) state_next = START;
      end
      START: begin
        if (cnt_reg == CNT_HALF) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == CNT_FULL) begin
          cnt_next     = '0;
          shift_next   = shift_in;
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt_reg == CNT_FULL) begin
          cnt_next   = '0;
          state_next = rxs ? IDLE : BREAK;
        end
      end
      BREAK: begin
        // A line stuck low must go high before another start bit is armed.
        cnt_next = '0;
        if (rxs) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      frame_err_reg <= ferr;
      overrun_reg   <= drop;
      if (load) begin
        data_reg  <= shift_reg;
        valid_reg <= 1'b1;
      end else if (valid_reg && rx.ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx.data      = data_reg;
  assign rx.valid     = valid_reg;
  assign rx.frame_err = frame_err_reg;
  assign rx.overrun   = overrun_reg;
  assign rx.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Bench for uart_rx_sipo: MSB-first instance checked through a byte scoreboard,
// LSB-first instance checked on a single frame.
module tb_uart_rx_sipo;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;

  uart_rx_sipo_if if_a ();
  uart_rx_sipo_if if_b ();

  uart_rx_sipo #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .clr(clr), .rxd(rxd_a), .rx(if_a.master)
  );
  uart_rx_sipo #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .clr(clr), .rxd(rxd_b), .rx(if_b.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb_q[$];
  int delivered = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int b_cnt = 0;
  int b_flags = 0;
  logic [7:0] b_last = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input bit line_b, input logic v);
    if (line_b) rxd_b = v;
    else rxd_a = v;
  endtask

  // Start bit, 8 data bits (order per instance), then a stop level held stop_len cycles.
  task automatic send_frame(input logic [7:0] b, input bit line_b, input logic stop_val,
                            input int stop_len);
    set_line(line_b, 1'b0);
    for (int i = 0; i < CPB; i++) begin
      @(posedge clk);
      #1;
      if (!line_b && i == 1) check("detect_early", 32'(if_a.busy), 0);
      if (!line_b && i == 2) check("detect_lat", 32'(if_a.busy), 1);
    end
    for (int j = 0; j < 8; j++) begin
      set_line(line_b, line_b ? b[j] : b[7-j]);
      wait_cycles(CPB);
    end
    set_line(line_b, stop_val);
    for (int i = 0; i < stop_len; i++) begin
      @(posedge clk);
      #1;
      if (!line_b && i == 10)
        check("stop_evt", 32'(if_a.valid | if_a.frame_err | if_a.overrun), 1);
    end
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      if (if_a.valid && if_a.ready) begin
        $display("rx_a data=%02h", if_a.data);
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 32'(sb_q.size()), 1);
        end else begin
          logic [7:0] exp_b;
          exp_b = sb_q.pop_front();
          check("sb_data", 32'(if_a.data), 32'(exp_b));
          delivered++;
        end
      end
      if (if_a.frame_err) ferr_cnt++;
      if (if_a.overrun) ovr_cnt++;
      if (if_b.valid) begin
        $display("rx_b data=%02h", if_b.data);
        b_cnt++;
        b_last = if_b.data;
      end
      if (if_b.frame_err || if_b.overrun) b_flags++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_a.ready = 1'b1;
    if_b.ready = 1'b1;
    clr = 1'b1;
    wait_cycles(3);
    check("rst_data", 32'(if_a.data), 0);
    check("rst_valid", 32'(if_a.valid), 0);
    check("rst_busy", 32'(if_a.busy), 0);
    check("rst_ferr", 32'(if_a.frame_err), 0);
    check("rst_ovr", 32'(if_a.overrun), 0);
    check("rst_b_valid", 32'(if_b.valid), 0);
    clr = 1'b0;
    wait_cycles(3);

    // 0xA5 MSB first, consumer ready
    sb_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, CPB);
    wait_cycles(4);
    check("a5_delivered", delivered, 1);
    check("a5_flags", ferr_cnt + ovr_cnt, 0);
    check("a5_idle", 32'(if_a.busy), 0);

    // 0xA5 LSB first on the second instance
    send_frame(8'hA5, 1'b1, 1'b1, CPB);
    wait_cycles(4);
    check("lsb_count", b_cnt, 1);
    check("lsb_data", 32'(b_last), 32'hA5);
    check("lsb_flags", b_flags, 0);

    // 4-cycle glitch: start detected, then rejected at the half-bit sample
    rxd_a = 1'b0;
    wait_cycles(4);
    rxd_a = 1'b1;
    wait_cycles(6);
    check("glitch_start", 32'(if_a.busy), 1);
    wait_cycles(4);
    check("glitch_idle", 32'(if_a.busy), 0);
    check("glitch_nodata", delivered, 1);
    check("glitch_flags", ferr_cnt + ovr_cnt, 0);

    // 0x3C with stop bit low, line held low 40 cycles
    send_frame(8'h3C, 1'b0, 1'b0, 40);
    check("brk_busy", 32'(if_a.busy), 1);
    check("brk_ferr", ferr_cnt, 1);
    rxd_a = 1'b1;
    wait_cycles(4);
    check("brk_idle", 32'(if_a.busy), 0);
    check("brk_nodata", delivered, 1);
    check("brk_ovr", ovr_cnt, 0);

    // consumer stalled: 0x11 held, 0x22 dropped with overrun
    if_a.ready = 1'b0;
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b1, CPB);
    send_frame(8'h22, 1'b0, 1'b1, CPB);
    wait_cycles(4);
    check("ovr_valid", 32'(if_a.valid), 1);
    check("ovr_data", 32'(if_a.data), 32'h11);
    check("ovr_pulse", ovr_cnt, 1);
    check("ovr_ferr", ferr_cnt, 1);
    if_a.ready = 1'b1;
    wait_cycles(1);
    check("ovr_clear", 32'(if_a.valid), 0);
    check("ovr_delivered", delivered, 2);

    // reset mid-frame of 0xFF, then 0x5A
    rxd_a = 1'b0;
    wait_cycles(CPB);
    rxd_a = 1'b1;
    wait_cycles(3 * CPB);
    check("clr_pre_busy", 32'(if_a.busy), 1);
    clr = 1'b1;
    wait_cycles(1);
    check("clr_busy", 32'(if_a.busy), 0);
    check("clr_valid", 32'(if_a.valid), 0);
    check("clr_data", 32'(if_a.data), 0);
    clr = 1'b0;
    wait_cycles(4);
    sb_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, CPB);
    wait_cycles(4);
    check("clr_delivered", delivered, 3);
    check("sb_drained", 32'(sb_q.size()), 0);
    check("end_ferr", ferr_cnt, 1);
    check("end_ovr", ovr_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_sipo.md
# uart_rx_sipo

Serial-to-parallel receive stage: consumes the 8N1 bit stream produced by the parallel-in/serial-out transmit shift register (MSB first, line idle high) and delivers each received byte on a valid/ready holding register. Oversamples the line at CLKS_PER_BIT system clocks per bit, samples mid-bit, and flags framing and overrun errors. Sits directly downstream of the transmit shift register's serial output, on the far end of the link.

## Interface
- CLKS_PER_BIT, 16: system clocks per bit period; even, ≥ 4.
- MSB_FIRST, 1: 1 = first data bit is byte bit 7 (matches the transmit shift register); 0 = LSB first.
- clk  in  1  system clock, all state on rising edge.
- clr  in  1  reset; one clock; reset is asynchronous and active-high.
- rxd  in  1  serial line, asynchronous to clk, idle high.
- data  out  8  received byte; valid only while `valid`=1.
- valid  out  1  holding register full.
- ready  in  1  consumer accepts `data` when `valid & ready`.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while holding register still full.
- busy  out  1  high in any state other than IDLE.

## Operation
- Reset values: data=0, valid=0, frame_err=0, overrun=0, busy=0; FSM=IDLE; synchronizer flops=1.
- rxd passes a 2-flop synchronizer; all decisions use the synchronized value `rxs`.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on rxs=0 → START, cnt=0.
- START: cnt counts; at cnt=CLKS_PER_BIT/2-1 sample rxs: 0 → DATA, cnt=0, bit index=0; 1 → IDLE (glitch rejected, no flag).
- DATA: at cnt=CLKS_PER_BIT-1 sample rxs into shift register, cnt=0, index++; after 8th sample → STOP.
- STOP: at cnt=CLKS_PER_BIT-1 sample rxs:
  - 1 and valid=0 (or valid=1 with ready=1 this same cycle): load data, valid=1 next cycle; → IDLE.
  - 1 and valid=1 with ready=0: drop new byte, keep old data, pulse overrun; → IDLE.
  - 0: pulse frame_err, no load; → BREAK.
- BREAK: wait for rxs=1, then → IDLE (line held low never re-triggers a frame).
- Handshake: valid clears the cycle after `valid & ready`; data stable while valid=1. Simultaneous accept and new load: new byte loaded, valid stays 1.
- MSB_FIRST=1: shift left, new bit into bit 0; MSB_FIRST=0: shift right, new bit into bit 7.
- cnt width $clog2(CLKS_PER_BIT); never wraps mid-bit (reset to 0 at each sample).
- clr mid-frame: immediate return to reset values; partial byte discarded.

## Timing
- rxd falling edge → FSM leaves IDLE: 3 cycles (2 sync + 1 detect).
- Start sample: CLKS_PER_BIT/2 cycles after entering START; data bit n sample: (n+1)·CLKS_PER_BIT cycles after start sample; stop sample 9·CLKS_PER_BIT after start sample.
- valid / frame_err / overrun assert the cycle after the stop sample.
- Back-to-back frames: a start bit immediately following the stop bit is accepted (IDLE→START with no dead cycle beyond detection).

## Structure
- Shared package uart_pkg: state enum uart_rx_state_t (IDLE, START, DATA, STOP, BREAK), constant UART_DATA_BITS=8.
- One sub-module: sync2 (2-flop synchronizer, parameterized reset value, reset to 1 here).
- FSM, bit counter, shift register and holding register in the top module.

## Test plan
- Frame 0xA5, MSB_FIRST=1, CLKS_PER_BIT=16, ready=1 → valid pulses 1 cycle with data=0xA5, no flags.
- Frame 0xA5, MSB_FIRST=0 → data=0xA5 bit-reversed order received, i.e. data=0xA5 when line carries 1,0,1,0,0,1,0,1 LSB-first.
- Start pulse 4 cycles low then high → FSM returns to IDLE, no valid, no flags.
- Frame 0x3C with stop bit 0, line held low 40 cycles → frame_err pulse once, no valid, busy until line high.
- ready=0, frames 0x11 then 0x22 back-to-back → valid=1 data=0x11, overrun pulse at 2nd stop sample, data stays 0x11; ready=1 clears valid next cycle.
- clr asserted mid DATA of frame 0xFF, released, then frame 0x5A → only 0x5A delivered.
